// File: rtl/rv_timer_alarm_sched.sv
// rv_timer_alarm_sched: earliest-deadline-first alarm scheduler sharing the
// single 64-bit compare channel of rv_timer (hart 0, timer 0).
// It is the TL-UL host on the timer register port. After reset it configures
// the timer, keeps the compare registers loaded with the earliest pending
// deadline, and retires the requester it is serving on each expiry interrupt.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/_ready_o  per-slot deadline handshake
//   req_deadline_i        per-slot absolute 64-bit timer deadline
//   done_o                one-cycle pulse when a slot's alarm retires
//   tl_o / tl_i           TL-UL host request / device response
//   intr_timer_expired_i  rv_timer expiry interrupt
//   busy_o                FSM is outside IDLE and ARMED
//   err_o                 sticky, set on any d_error

package tlul_pkg;
  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] AccessAck   = 3'h0;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module rv_timer_alarm_sched #(
  parameter int unsigned NumReq        = 4,
  parameter logic [11:0] Prescale      = 12'd0,
  parameter logic [7:0]  Step          = 8'd1,
  parameter logic [31:0] AddrCtrl      = 32'h000,
  parameter logic [31:0] AddrIntrEn    = 32'h100,
  parameter logic [31:0] AddrIntrState = 32'h104,
  parameter logic [31:0] AddrCfg       = 32'h10c,
  parameter logic [31:0] AddrCmpLo     = 32'h118,
  parameter logic [31:0] AddrCmpHi     = 32'h11c
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  input  logic [NumReq-1:0][63:0]  req_deadline_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [NumReq-1:0]        done_o,
  output tlul_pkg::tl_h2d_t        tl_o,
  input  tlul_pkg::tl_d2h_t        tl_i,
  input  logic                     intr_timer_expired_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [3:0] S_INIT_CFG  = 4'd0;
  localparam logic [3:0] S_INIT_IE   = 4'd1;
  localparam logic [3:0] S_INIT_CTRL = 4'd2;
  localparam logic [3:0] S_IDLE      = 4'd3;
  localparam logic [3:0] S_SEL       = 4'd4;
  localparam logic [3:0] S_WR_HI_MAX = 4'd5;
  localparam logic [3:0] S_WR_LO     = 4'd6;
  localparam logic [3:0] S_WR_HI     = 4'd7;
  localparam logic [3:0] S_ARMED     = 4'd8;
  localparam logic [3:0] S_CLR       = 4'd9;

  logic [3:0]              state_q, state_d;
  logic                    sent_q, sent_d;
  logic [NumReq-1:0]       pending_q, pending_d;
  logic [NumReq-1:0][63:0] dl_q, dl_d;
  logic [IdxW-1:0]         cur_idx_q, cur_idx_d;
  logic [63:0]             cur_dl_q, cur_dl_d;
  logic [NumReq-1:0]       done_q, done_d;
  logic                    err_q, err_d;

  logic                    sel_found;
  logic [IdxW-1:0]         sel_idx;
  logic [63:0]             sel_dl;
  logic                    preempt;
  logic                    is_wr;
  logic [31:0]             wr_addr, wr_data;
  logic                    wr_done;
  logic                    init;
  logic [NumReq-1:0]       accept;
  logic                    unused_tl;

  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_data};

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_dl    = '1;
    preempt   = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (pending_q[i] && (!sel_found || dl_q[i] < sel_dl)) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        sel_dl    = dl_q[i];
      end
      if (pending_q[i] && dl_q[i] < cur_dl_q) preempt = 1'b1;
    end
  end

  always_comb begin
    is_wr   = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_INIT_CFG:  begin wr_addr = AddrCfg;       wr_data = {8'h00, Step, 4'h0, Prescale}; end
      S_INIT_IE:   begin wr_addr = AddrIntrEn;    wr_data = 32'd1; end
      S_INIT_CTRL: begin wr_addr = AddrCtrl;      wr_data = 32'd1; end
      S_WR_HI_MAX: begin wr_addr = AddrCmpHi;     wr_data = '1; end
      S_WR_LO:     begin wr_addr = AddrCmpLo;     wr_data = cur_dl_q[31:0]; end
      S_WR_HI:     begin wr_addr = AddrCmpHi;     wr_data = cur_dl_q[63:32]; end
      S_CLR:       begin wr_addr = AddrIntrState; wr_data = 32'd1; end
      default:     is_wr = 1'b0;
    endcase
  end

  // a_valid is decoded from state so each write issues in its first cycle;
  // gating with rst_ni keeps it low while reset is held and drops it at once
  // when reset is asserted mid-transaction.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = rst_ni && is_wr && !sent_q;
    tl_o.a_opcode  = tlul_pkg::PutFullData;
    tl_o.a_size    = 2'd2;
    tl_o.a_mask    = 4'hF;
    tl_o.a_address = wr_addr;
    tl_o.a_data    = wr_data;
    tl_o.d_ready   = 1'b1;
  end

  assign init    = (state_q == S_INIT_CFG) || (state_q == S_INIT_IE) ||
                   (state_q == S_INIT_CTRL);
  // Masking with done_q delays readiness to the cycle after the done pulse.
  assign req_ready_o = ~pending_q & ~done_q & {NumReq{!init}};
  assign accept  = req_valid_i & req_ready_o;
  assign wr_done = sent_q && tl_i.d_valid;

  always_comb begin
    state_d   = state_q;
    sent_d    = sent_q;
    pending_d = pending_q | accept;
    dl_d      = dl_q;
    cur_idx_d = cur_idx_q;
    cur_dl_d  = cur_dl_q;
    done_d    = '0;
    err_d     = err_q;

    for (int unsigned i = 0; i < NumReq; i++) begin
      if (accept[i]) dl_d[i] = req_deadline_i[i];
    end

    if (is_wr && !sent_q && tl_i.a_ready) sent_d = 1'b1;
    if (wr_done) begin
      sent_d = 1'b0;
      if (tl_i.d_error) err_d = 1'b1;
    end

    case (state_q)
      S_INIT_CFG:  if (wr_done) state_d = S_INIT_IE;
      S_INIT_IE:   if (wr_done) state_d = S_INIT_CTRL;
      S_INIT_CTRL: if (wr_done) state_d = S_IDLE;
      S_IDLE:      if (|pending_q) state_d = S_SEL;
      S_SEL: begin
        cur_idx_d = sel_idx;
        cur_dl_d  = sel_dl;
        state_d   = S_WR_HI_MAX;
      end
      S_WR_HI_MAX: if (wr_done) state_d = S_WR_LO;
      S_WR_LO:     if (wr_done) state_d = S_WR_HI;
      S_WR_HI:     if (wr_done) state_d = S_ARMED;
      S_ARMED: begin
        if (intr_timer_expired_i) state_d = S_CLR;
        else if (preempt)         state_d = S_SEL;
      end
      S_CLR: begin
        if (wr_done) begin
          done_d[cur_idx_q]    = 1'b1;
          pending_d[cur_idx_q] = 1'b0;
          state_d              = S_IDLE;
        end
      end
      default: state_d = S_INIT_CFG;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_INIT_CFG;
      sent_q    <= 1'b0;
      pending_q <= '0;
      dl_q      <= '0;
      cur_idx_q <= '0;
      cur_dl_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sent_q    <= sent_d;
      pending_q <= pending_d;
      dl_q      <= dl_d;
      cur_idx_q <= cur_idx_d;
      cur_dl_q  <= cur_dl_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign done_o = done_q;
  assign busy_o = !((state_q == S_IDLE) || (state_q == S_ARMED));
  assign err_o  = err_q;

endmodule

// File: tb/tb_rv_timer_alarm_sched.sv
// Testbench for rv_timer_alarm_sched: a small rv_timer register/counter model
// answers the TL-UL writes; expected writes and done pulses are queued by the
// stimulus and consumed by an independent monitor.
module tb_rv_timer_alarm_sched;
  localparam int unsigned N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][63:0]  req_dl = '0;
  logic [N-1:0]        req_ready, done;
  tlul_pkg::tl_h2d_t   tl_h;
  tlul_pkg::tl_d2h_t   tl_d;
  logic                intr_q = 1'b0;
  logic                busy, err;

  rv_timer_alarm_sched #(.NumReq(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_deadline_i(req_dl), .req_ready_o(req_ready),
    .done_o(done), .tl_o(tl_h), .tl_i(tl_d),
    .intr_timer_expired_i(intr_q), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // ---------------- timer device model ----------------
  logic [31:0] r_cfg = '0, r_ie = '0, r_ctrl = '0, r_lo = '0, r_hi = '0;
  logic [63:0] mtime = '0;
  logic [11:0] pre_cnt = '0;
  logic        d_valid_q = 1'b0, d_err_q = 1'b0;
  logic        stall_lo = 1'b0, err_lo = 1'b0, tm_load = 1'b0, tm_freeze = 1'b0;
  logic [63:0] tm_val = '0;

  always_comb begin
    tl_d         = '0;
    tl_d.d_valid = d_valid_q;
    tl_d.d_error = d_err_q;
    tl_d.a_ready = !(stall_lo && tl_h.a_address == 32'h118);
  end

  always @(posedge clk) begin
    d_valid_q <= 1'b0;
    d_err_q   <= 1'b0;
    if (tl_h.a_valid && tl_d.a_ready) begin
      d_valid_q <= 1'b1;
      d_err_q   <= err_lo && (tl_h.a_address == 32'h118);
      case (tl_h.a_address)
        32'h10c: r_cfg  <= tl_h.a_data;
        32'h100: r_ie   <= tl_h.a_data;
        32'h000: r_ctrl <= tl_h.a_data;
        32'h118: r_lo   <= tl_h.a_data;
        32'h11c: r_hi   <= tl_h.a_data;
        default: ;
      endcase
    end
    if (tm_load) begin
      mtime   <= tm_val;
      pre_cnt <= '0;
    end else if (r_ctrl[0] && !tm_freeze) begin
      if (pre_cnt >= r_cfg[11:0]) begin
        pre_cnt <= '0;
        mtime   <= mtime + 64'(r_cfg[23:16]);
      end else begin
        pre_cnt <= pre_cnt + 12'd1;
      end
    end
    intr_q <= r_ie[0] && (mtime >= {r_hi, r_lo});
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [N-1:0] vec; logic [63:0] tmin; logic [63:0] tmax; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int  n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (tl_h.a_valid && tl_d.a_ready) begin
      if (exp_wr.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %h data %h required no write",
                 tl_h.a_address, tl_h.a_data);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(tl_h.a_address), 64'(w.addr));
        chk("wr_data", 64'(tl_h.a_data), 64'(w.data));
        chk("wr_attr", 64'({tl_h.a_opcode, tl_h.a_size, tl_h.a_mask, tl_h.a_source}),
            64'({3'h0, 2'd2, 4'hF, 8'h00}));
      end
    end
    if (done != '0) begin
      if (exp_dn.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got %b required none", done);
      end else begin
        dn_t d;
        d = exp_dn.pop_front();
        chk("done_vec", 64'(done), 64'(d.vec));
        chk("done_time_in_window", 64'(mtime >= d.tmin && mtime <= d.tmax), 64'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic exp_init();
    exp_w(32'h10c, 32'h0001_0000);
    exp_w(32'h100, 32'd1);
    exp_w(32'h000, 32'd1);
  endtask

  task automatic exp_arm(input logic [63:0] dl);
    exp_w(32'h11c, 32'hFFFF_FFFF);
    exp_w(32'h118, dl[31:0]);
    exp_w(32'h11c, dl[63:32]);
  endtask

  task automatic exp_clr_done(input logic [N-1:0] v, input logic [63:0] tmin,
                              input logic [63:0] tmax);
    dn_t d;
    exp_w(32'h104, 32'd1);
    d.vec = v; d.tmin = tmin; d.tmax = tmax;
    exp_dn.push_back(d);
  endtask

  task automatic post(input int idx, input logic [63:0] dl);
    chk("ready_before_post", 64'(req_ready[idx]), 64'd1);
    req_valid[idx] = 1'b1;
    req_dl[idx]    = dl;
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic load_time(input logic [63:0] v);
    tm_val  = v;
    tm_load = 1'b1;
    tick();
    tm_load = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_wr.size() != 0 || exp_dn.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    chk(name, 64'(exp_wr.size() + exp_dn.size()), 64'd0);
    tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;

    // Reset values and init sequence
    tick(2);
    chk("rst_a_valid", 64'(tl_h.a_valid), 64'd0);
    chk("rst_d_ready", 64'(tl_h.d_ready), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    exp_init();
    rst_n = 1'b1;
    tick(5);
    chk("init_not_ready_at_5", 64'(req_ready), 64'h0);
    tick();
    chk("init_ready_at_6", 64'(req_ready), 64'hF);
    chk("init_idle", 64'(busy), 64'd0);

    // Single alarm, plus accept-to-ARMED latency
    load_time(64'd0);
    exp_arm(64'd200);
    exp_clr_done(4'b0001, 64'd200, 64'd240);
    post(0, 64'd200);
    tick(7);
    chk("arm_busy_at_7", 64'(busy), 64'd1);
    tick();
    chk("armed_at_8", 64'(busy), 64'd0);
    wait_drain("single_drain", 400);

    // EDF ordering with a tie
    load_time(64'd0);
    exp_arm(64'd300); exp_clr_done(4'b0100, 64'd300, 64'd340);
    exp_arm(64'd300); exp_clr_done(4'b1000, 64'd300, 64'd340);
    exp_arm(64'd500); exp_clr_done(4'b0010, 64'd500, 64'd540);
    req_dl[1] = 64'd500; req_dl[2] = 64'd300; req_dl[3] = 64'd300;
    req_valid = 4'b1110;
    tick();
    req_valid = '0;
    wait_drain("edf_drain", 800);

    // Preemption
    load_time(64'd0);
    exp_arm(64'd1000);
    post(0, 64'd1000);
    tick(15);
    exp_arm(64'd400);  exp_clr_done(4'b0100, 64'd400, 64'd440);
    exp_arm(64'd1000); exp_clr_done(4'b0001, 64'd1000, 64'd1040);
    post(2, 64'd400);
    wait_drain("preempt_drain", 1500);

    // Past deadline of 0
    exp_arm(64'd0);
    exp_clr_done(4'b0001, 64'd0, '1);
    post(0, 64'd0);
    lat = 1;
    while (done == '0 && lat < 30) begin tick(); lat++; end
    chk("past_latency_le12", 64'(lat <= 12), 64'd1);
    wait_drain("past_drain", 100);

    // Deadline crossing the 32-bit boundary
    load_time(64'h0000_0000_FFFF_FF00);
    exp_arm(64'h1_0000_0000);
    exp_clr_done(4'b0001, 64'h1_0000_0000, 64'h1_0000_0028);
    post(0, 64'h1_0000_0000);
    wait_drain("boundary_drain", 600);

    // Interrupt and earlier request in the same ARMED cycle
    tm_freeze = 1'b1;
    load_time(64'd0);
    exp_arm(64'd100);
    post(0, 64'd100);
    tick(12);
    exp_clr_done(4'b0001, 64'd100, 64'd300);
    exp_arm(64'd5);
    exp_clr_done(4'b0010, 64'd5, 64'd300);
    tm_val = 64'd200; tm_load = 1'b1;
    tick();
    tm_load = 1'b0;
    req_dl[1] = 64'd5; req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    wait_drain("simul_drain", 200);
    tm_freeze = 1'b0;

    // d_error on CMP_LO
    chk("err_clear_before", 64'(err), 64'd0);
    err_lo = 1'b1;
    exp_arm(64'd0);
    exp_clr_done(4'b0001, 64'd0, '1);
    post(0, 64'd0);
    wait_drain("err_drain", 100);
    chk("err_set", 64'(err), 64'd1);
    tick(5);
    chk("err_sticky", 64'(err), 64'd1);
    err_lo = 1'b0;

    // Reset during WR_LO with a_valid held
    stall_lo = 1'b1;
    exp_w(32'h11c, 32'hFFFF_FFFF);
    req_dl[0] = 64'd5000; req_dl[1] = 64'd6000;
    req_valid = 4'b0011;
    tick();
    req_valid = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (tl_h.a_valid && tl_h.a_address == 32'h118) found = 1'b1;
      else tick();
    end
    chk("wr_lo_stalled", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_a_valid", 64'(tl_h.a_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    chk("rst_mid_err", 64'(err), 64'd0);
    chk("rst_mid_wr_queue", 64'(exp_wr.size()), 64'd0);
    exp_init();
    stall_lo = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rerun_slots_empty", 64'(req_ready), 64'hF);
    chk("rerun_idle", 64'(busy), 64'd0);
    tick(20);

    chk("leftover_writes", 64'(exp_wr.size()), 64'd0);
    chk("leftover_dones", 64'(exp_dn.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
